uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-stream handshake and serial line bundle for uart_tx.
// The master offers bytes; the slave (the transmitter) drives ready, done and the line.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_done;
  logic       tx;

  modport master (
    output tx_valid,
    output tx_byte,
    input  tx_ready,
    input  tx_done,
    input  tx
  );

  modport slave (
    input  tx_valid,
    input  tx_byte,
    output tx_ready,
    output tx_done,
    output tx
  );
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Each line bit is held for CLK_HZ/BAUD clocks; tx_done marks the last clock of the stop bit.
module uart_tx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       byte_q;
  logic             tx_q;
  logic             done_q;

  // Ready is purely a function of state, so it drops on the acceptance edge itself.
  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.tx       = tx_q;
  assign bus.tx_done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          idx_q <= '0;
          if (bus.tx_valid) begin
            byte_q  <= bus.tx_byte;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= byte_q[0];
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            // Index wraps 7 -> 0 here; leaving DATA on index 7 prevents a ninth bit.
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= ^byte_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              tx_q <= byte_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          tx_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // Registered, so asserting one count early lands the pulse on the final stop clock.
            if (cnt_q == CNT_PRE) begin
              done_q <= 1'b1;
            end
          end
        end

        default: begin
          tx_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-written line patterns,
// a monitor follows the serial line clock by clock and checks each frame against them.
module tb_uart_tx;

  localparam int CPB   = 12000000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int LIMIT = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_if bus ();

  uart_tx #(.CLK_HZ(12000000), .BAUD(115200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          gap;
    bit          abort_exp;
    logic [7:0]  b;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Frames are written in line order: leftmost literal bit is the start bit.
  task automatic send(input logic [7:0] b, input logic [9:0] f10, input logic [10:0] f11,
                      input int gap, input bit abort_exp, input bit hold);
    exp_t e;
    int   n;
    e.b         = b;
    e.gap       = gap;
    e.abort_exp = abort_exp;
    e.bits      = '0;
    for (int k = 0; k < NB; k++) begin
`ifdef UART_TX_PARITY_EN
      e.bits[k] = f11[NB-1-k];
`else
      e.bits[k] = f10[NB-1-k];
`endif
    end
    sb.push_back(e);
    @(negedge clk);
    bus.tx_byte  = b;
    bus.tx_valid = 1'b1;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout_%02h: tx_ready got %b after %0d cycles, required 1", b, bus.tx_ready, n);
      bus.tx_valid = 1'b0;
      return;
    end
    check($sformatf("idle_before_accept_%02h", b), 32'(bus.tx), 32'd1);
    @(posedge clk);
    #1;
    check($sformatf("start_latency_%02h", b), 32'({bus.tx, bus.tx_ready}), 32'd0);
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.tx_ready !== 1'b1) && n < 2 * LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    int   last_end;
    int   start_cyc;
    int   total;
    int   bad;
    int   first_bad_c;
    bit   aborted;
    bit   done_seen;
    logic expbit;
    exp_t e;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || bus.tx !== 1'b0) continue;
      start_cyc = cyc;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", start_cyc);
        for (int k = 0; k < NB * CPB && bus.tx !== 1'b1; k++) @(negedge clk);
        continue;
      end
      e           = sb[0];
      total       = NB * CPB;
      bad         = 0;
      first_bad_c = 0;
      aborted     = 1'b0;
      done_seen   = 1'b0;
      for (int c = 1; c <= total; c++) begin
        if (c > 1) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        expbit = e.bits[(c-1)/CPB];
        if (bus.tx_done === 1'b1) done_seen = 1'b1;
        if (bus.tx !== expbit || bus.tx_done !== (c == total) || bus.tx_ready !== 1'b0) begin
          if (bad == 0) first_bad_c = c;
          bad++;
        end
      end
      void'(sb.pop_front());
      if (aborted) begin
        check($sformatf("abort_expected_%02h", e.b), 32'd1, 32'(e.abort_exp));
        check($sformatf("abort_no_done_%02h", e.b), 32'(done_seen), 32'd0);
        wait (rst_n === 1'b1);
        continue;
      end
      if (e.abort_exp) bad++;
      check($sformatf("frame_%02h_bad_clocks_first_at_%0d", e.b, first_bad_c), 32'(bad), 32'd0);
      if (e.gap >= 0) check($sformatf("idle_gap_before_%02h", e.b), 32'(start_cyc - last_end - 1), 32'(e.gap));
      last_end = cyc;
      @(negedge clk);
      check($sformatf("idle_after_%02h", e.b), 32'({bus.tx, bus.tx_ready, bus.tx_done}), 32'b110);
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.tx_valid = 1'b0;
    bus.tx_byte  = 8'h00;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({bus.tx, bus.tx_ready, bus.tx_done}), 32'b110);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 32'({bus.tx, bus.tx_ready, bus.tx_done}), 32'b110);

    // Single byte.
    send(8'hA5, 10'b0_1010_0101_1, 11'b0_1010_0101_0_1, -1, 1'b0, 1'b0);
    drain();

    // Back-to-back with tx_valid held high.
    send(8'h00, 10'b0_0000_0000_1, 11'b0_0000_0000_0_1, -1, 1'b0, 1'b1);
    send(8'hFF, 10'b0_1111_1111_1, 11'b0_1111_1111_0_1,  1, 1'b0, 1'b0);
    drain();

    // Input change and stray valid during DATA.
    send(8'h3C, 10'b0_0011_1100_1, 11'b0_0011_1100_0_1, -1, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    bus.tx_byte  = 8'hC3;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    drain();

    // Reset during data bit 4, then a clean frame.
    send(8'h81, 10'b0_1000_0001_1, 11'b0_1000_0001_0_1, -1, 1'b1, 1'b0);
    repeat (570) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame", 32'({bus.tx, bus.tx_ready, bus.tx_done}), 32'b110);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h55, 10'b0_1010_1010_1, 11'b0_1010_1010_0_1, -1, 1'b0, 1'b0);
    drain();

    // Odd and even parity data.
    send(8'h07, 10'b0_1110_0000_1, 11'b0_1110_0000_1_1, -1, 1'b0, 1'b0);
    drain();
    send(8'h03, 10'b0_1100_0000_1, 11'b0_1100_0000_0_1, -1, 1'b0, 1'b0);
    drain();

    check("tx_done_pulse_count", 32'(done_cnt), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
